// File: rtl/vid_timing_pkg.sv
`default_nettype none
// ============================================================================
// vid_timing_pkg : raster timing record, resolution presets, state encoding
// Rev 1.0
// ============================================================================
package vid_timing_pkg;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_fp;
    logic [15:0] h_sync;
    logic [15:0] h_bp;
    logic [15:0] v_active;
    logic [15:0] v_fp;
    logic [15:0] v_sync;
    logic [15:0] v_bp;
  } vid_timing_t;

  localparam vid_timing_t VT_1080P60 = '{
    h_active: 16'd1920, h_fp: 16'd88, h_sync: 16'd44, h_bp: 16'd148,
    v_active: 16'd1080, v_fp: 16'd4,  v_sync: 16'd5,  v_bp: 16'd36
  };

  localparam vid_timing_t VT_960X540 = '{
    h_active: 16'd960, h_fp: 16'd44, h_sync: 16'd22, h_bp: 16'd74,
    v_active: 16'd540, v_fp: 16'd2,  v_sync: 16'd3,  v_bp: 16'd18
  };

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } vid_state_e;

  function automatic int unsigned tot(input int unsigned active,
                                      input int unsigned fp,
                                      input int unsigned sync,
                                      input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage : vid_timing_pkg
`default_nettype wire

// File: rtl/vid_axis_cnt.sv
`default_nettype none
// ============================================================================
// vid_axis_cnt : one raster axis counter with wrap and region decodes
// Rev 1.0
// ============================================================================
module vid_axis_cnt
  import vid_timing_pkg::*;
#(
  parameter int          CW     = 12,
  parameter int unsigned ACTIVE = 1920,
  parameter int unsigned FP     = 88,
  parameter int unsigned SYNC   = 44,
  parameter int unsigned BP     = 148
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          last,
  output logic          zero,
  output logic          active,
  output logic          sync_region
);

  localparam int unsigned   c_total    = tot(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] c_last     = CW'(c_total - 1);
  localparam logic [CW-1:0] c_act      = CW'(ACTIVE);
  localparam logic [CW-1:0] c_sync_beg = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] c_sync_end = CW'(ACTIVE + FP + SYNC);

  if (longint'(c_total) >= (longint'(1) << CW)) begin : g_total_overflow
    $error("vid_axis_cnt: axis total %0d does not fit in %0d bits", c_total, CW);
  end

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
    end
  end

  assign cnt         = r_cnt;
  assign last        = (r_cnt == c_last);
  assign zero        = (r_cnt == '0);
  assign active      = (r_cnt < c_act);
  assign sync_region = (r_cnt >= c_sync_beg) && (r_cnt < c_sync_end);

endmodule : vid_axis_cnt
`default_nettype wire

// File: rtl/vid_timing_gen.sv
`default_nettype none
// ============================================================================
// vid_timing_gen : enable-gated raster timing generator (whole frames only)
// Rev 1.0
// ============================================================================
module vid_timing_gen
  import vid_timing_pkg::*;
#(
  parameter int          CW       = 12,
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned H_FP     = 88,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BP     = 148,
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 36,
  parameter logic        HS_POL   = 1'b1,
  parameter logic        VS_POL   = 1'b1
) (
  input  logic          pixel_clk,
  input  logic          pixel_rst,
  input  logic          enable,
  output logic          pixel_de,
  output logic          pixel_hs,
  output logic          pixel_vs,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          frame_start,
  output logic          busy,
  output logic [15:0]   frame_cnt,
  output logic [31:0]   image_width,
  output logic [31:0]   image_height
);

  localparam logic [0:0] IDLE = S_IDLE;
  localparam logic [0:0] RUN  = S_RUN;

  logic [0:0]    r_state;
  logic [15:0]   r_frame_cnt;
  logic          w_run;
  logic          w_frame_end;
  logic          w_de;
  logic [CW-1:0] w_h_cnt, w_v_cnt;
  logic          w_h_last, w_v_last, w_h_zero, w_v_zero;
  logic          w_h_act, w_v_act, w_h_sync, w_v_sync;

  assign w_run       = (r_state == RUN);
  assign w_frame_end = w_run && w_h_last && w_v_last;
  assign w_de        = w_run && w_h_act && w_v_act;

  // Both counters are held at zero while idle so a start always lands on (0,0).
  vid_axis_cnt #(
    .CW(CW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_cnt (
    .clk         (pixel_clk),
    .rst         (pixel_rst),
    .clr         (!w_run),
    .inc         (1'b1),
    .cnt         (w_h_cnt),
    .last        (w_h_last),
    .zero        (w_h_zero),
    .active      (w_h_act),
    .sync_region (w_h_sync)
  );

  vid_axis_cnt #(
    .CW(CW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_cnt (
    .clk         (pixel_clk),
    .rst         (pixel_rst),
    .clr         (!w_run),
    .inc         (w_h_last),
    .cnt         (w_v_cnt),
    .last        (w_v_last),
    .zero        (w_v_zero),
    .active      (w_v_act),
    .sync_region (w_v_sync)
  );

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      r_state     <= IDLE;
      r_frame_cnt <= '0;
    end else begin
      case (r_state)
        IDLE:    if (enable) r_state <= RUN;
        RUN:     if (w_frame_end && !enable) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      pixel_de    <= 1'b0;
      pixel_hs    <= ~HS_POL;
      pixel_vs    <= ~VS_POL;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      pixel_de    <= w_de;
      pixel_hs    <= (w_run && w_h_sync) ? HS_POL : ~HS_POL;
      pixel_vs    <= (w_run && w_v_sync) ? VS_POL : ~VS_POL;
      pixel_x     <= w_de ? w_h_cnt : '0;
      pixel_y     <= w_de ? w_v_cnt : '0;
      frame_start <= w_run && w_h_zero && w_v_zero;
      busy        <= w_run;
    end
  end

  assign frame_cnt    = r_frame_cnt;
  assign image_width  = H_ACTIVE;
  assign image_height = V_ACTIVE;

endmodule : vid_timing_gen
`default_nettype wire

// File: tb/tb_vid_timing_gen.sv
`default_nettype none
// ============================================================================
// tb_vid_timing_gen : directed bench, 16x8 raster, both sync polarities
// Rev 1.0
// ============================================================================
module tb_vid_timing_gen;

  localparam int CW    = 12;
  localparam int FRAME = 128;
  localparam int NEVER = 1 << 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;

  logic          de_p, hs_p, vs_p, fs_p, busy_p;
  logic [CW-1:0] x_p, y_p;
  logic [15:0]   fc_p;
  logic [31:0]   iw_p, ih_p;

  logic          de_n, hs_n, vs_n, fs_n, busy_n;
  logic [CW-1:0] x_n, y_n;
  logic [15:0]   fc_n;
  logic [31:0]   iw_n, ih_n;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  vid_timing_gen #(
    .CW(CW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .pixel_clk(clk), .pixel_rst(rst), .enable(enable),
    .pixel_de(de_p), .pixel_hs(hs_p), .pixel_vs(vs_p),
    .pixel_x(x_p), .pixel_y(y_p), .frame_start(fs_p), .busy(busy_p),
    .frame_cnt(fc_p), .image_width(iw_p), .image_height(ih_p)
  );

  vid_timing_gen #(
    .CW(CW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_n (
    .pixel_clk(clk), .pixel_rst(rst), .enable(enable),
    .pixel_de(de_n), .pixel_hs(hs_n), .pixel_vs(vs_n),
    .pixel_x(x_n), .pixel_y(y_n), .frame_start(fs_n), .busy(busy_n),
    .frame_cnt(fc_n), .image_width(iw_n), .image_height(ih_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Expected outputs: idle/reset levels, or output index p within a 16x8 frame.
  task automatic chk_out(input string tag, input bit idle, input int p, input int fc);
    int  h, v;
    bit  de, hs, vs;
    h  = p % 16;
    v  = p / 16;
    de = !idle && (h < 8) && (v < 4);
    hs = !idle && (h >= 10) && (h <= 12);
    vs = !idle && (v >= 5) && (v <= 6);
    chk({tag, " de"},    de_p,   32'(de));
    chk({tag, " hs"},    hs_p,   32'(hs));
    chk({tag, " vs"},    vs_p,   32'(vs));
    chk({tag, " x"},     x_p,    de ? 32'(h) : 32'd0);
    chk({tag, " y"},     y_p,    de ? 32'(v) : 32'd0);
    chk({tag, " fs"},    fs_p,   32'(!idle && p == 0));
    chk({tag, " busy"},  busy_p, 32'(!idle));
    chk({tag, " fcnt"},  fc_p,   32'(fc));
    chk({tag, " de_n"},  de_n,   32'(de));
    chk({tag, " hs_n"},  hs_n,   32'(!hs));
    chk({tag, " vs_n"},  vs_n,   32'(!vs));
    chk({tag, " fs_n"},  fs_n,   32'(!idle && p == 0));
  endtask

  // enable goes high now; the edge that samples it must still show idle outputs.
  task automatic start_frame(input string tag, input int fc);
    enable = 1'b1;
    tick();
    chk_out({tag, " start"}, 1'b1, 0, fc);
  endtask

  // k indexes output edges from the first active pixel of the span.
  task automatic run_span(input string tag, input int n, input int off1, input int on1,
                          input int off2, input int idle_from, input int fc0);
    for (int k = 0; k < n; k++) begin
      int done;
      tick();
      done = (k + 1 < idle_from) ? (k + 1) : idle_from;
      chk_out($sformatf("%s k=%0d", tag, k), k >= idle_from, k % FRAME, fc0 + done / FRAME);
      if (k == off1) enable = 1'b0;
      if (k == on1)  enable = 1'b1;
      if (k == off2) enable = 1'b0;
    end
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    tick();
    tick();
    chk_out("reset", 1'b1, 0, 0);
    chk("width",  iw_p, 32'd8);
    chk("height", ih_p, 32'd4);

    rst = 1'b0;
    tick();
    chk_out("idle no enable", 1'b1, 0, 0);

    // Enable dropped during line 1 of frame 0: the frame still completes.
    start_frame("A", 0);
    run_span("A", FRAME + 16, 20, -1, -1, FRAME, 0);

    rst = 1'b1;
    tick();
    chk_out("reset after A", 1'b1, 0, 0);
    rst = 1'b0;

    // Three back-to-back frames, enable dropped in the third.
    start_frame("B", 0);
    run_span("B", 3 * FRAME + 16, 2 * FRAME + 44, -1, -1, 3 * FRAME, 0);

    // Enable high only on the frame-end cycle chains exactly one more frame.
    start_frame("C", 3);
    run_span("C", 2 * FRAME + 16, 0, FRAME - 2, FRAME - 1, 2 * FRAME, 3);

    // Reset while the output shows h=5, v=2, then restart from (0,0).
    start_frame("D", 5);
    run_span("D", 2 * 16 + 6, -1, -1, -1, NEVER, 5);
    rst = 1'b1;
    tick();
    chk_out("D reset mid-line", 1'b1, 0, 0);
    rst = 1'b0;
    start_frame("D2", 0);
    run_span("D2", 40, -1, -1, -1, NEVER, 0);
    enable = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_vid_timing_gen
`default_nettype wire

// File: doc/vid_timing_gen.md
Name: vid_timing_gen

Overview:
- Video timing generator in the pixel_clk domain, directly upstream of pattern_fetch_send.
- Produces pixel_de/hs/vs/x/y raster timing consumed by the pattern sender.
- Gated by the sender's pat_ready_out: frames start only when the pattern buffer is ready, and a frame in progress is never truncated.

Parameters:
- CW, 12, width of counters and pixel_x/pixel_y.
- H_ACTIVE, 1920, active pixels per line.
- H_FP, 88, horizontal front porch.
- H_SYNC, 44, hsync width.
- H_BP, 148, horizontal back porch.
- V_ACTIVE, 1080, active lines.
- V_FP, 4, vertical front porch.
- V_SYNC, 5, vsync width.
- V_BP, 36, vertical back porch.
- HS_POL, 1, hsync active level.
- VS_POL, 1, vsync active level.

Ports:
- pixel_clk  in  1  pixel clock.
- pixel_rst  in  1  synchronous, active-high reset.
- enable  in  1  run request; connected to pat_ready_out.
- pixel_de  out  1  active-video strobe.
- pixel_hs  out  1  horizontal sync, HS_POL active.
- pixel_vs  out  1  vertical sync, VS_POL active.
- pixel_x  out  CW  active column.
- pixel_y  out  CW  active row.
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0).
- busy  out  1  high while a frame is being generated.
- frame_cnt  out  16  completed-frame counter.
- image_width  out  32  constant H_ACTIVE.
- image_height  out  32  constant V_ACTIVE.

Behaviour:
- Interface:
  - One clock, pixel_clk. Reset pixel_rst is synchronous and active-high.
  - All flops update only on the pixel_clk rising edge.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Elaboration-time check that both are < 2^CW.
- Reset values:
  - pixel_de=0; pixel_hs=~HS_POL; pixel_vs=~VS_POL.
  - pixel_x=0; pixel_y=0; frame_start=0; busy=0; frame_cnt=0.
  - Internal: state=IDLE, h_cnt=v_cnt=0.
- State machine:
  - IDLE: counters held at 0, outputs at reset levels except frame_cnt. If enable=1, go to RUN with h_cnt=v_cnt=0.
  - RUN:
    - h_cnt increments and wraps at H_TOTAL-1 to 0.
    - On that wrap, v_cnt increments and wraps at V_TOTAL-1 to 0.
    - At the frame-end cycle (h=H_TOTAL-1, v=V_TOTAL-1): frame_cnt += 1 (wraps at 2^16).
    - At frame end, if enable=1, stay in RUN with counters to (0,0), giving a back-to-back frame with no gap.
    - At frame end, if enable=0, go to IDLE.
    - enable falling mid-frame is ignored until frame end.
- Output decode (registered, 1-cycle latency from counters):
  - de = RUN && h<H_ACTIVE && v<V_ACTIVE.
  - hs active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, every line including blanking lines.
  - vs active for whole lines V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
  - pixel_x = h when de, else 0. pixel_y = v when de, else 0.
  - frame_start = RUN && h==0 && v==0.
  - busy = (state==RUN), registered with the same latency.
- Latency: enable sampled high at edge T gives RUN with counters (0,0) after T. The first output edge with pixel_de=1 and frame_start=1 is T+1.
- Simultaneous events:
  - pixel_rst overrides everything, including a frame-end cycle.
  - Reset mid-frame: outputs take reset values at the next edge; no partial-frame completion.
  - enable=0 exactly on the frame-end cycle gives IDLE. enable=1 on that cycle gives a new frame.
- Arithmetic: counters are unsigned CW bits; comparisons use parameter constants only (no runtime division).

Decomposition:
- vid_timing_pkg holds:
  - typedef struct vid_timing_t (h_active, h_fp, h_sync, h_bp, v_*), plus 1080p60 and 960x540 constants.
  - state enum {IDLE, RUN}.
  - function tot() for summing porches.
- One sub-module, vid_axis_cnt: a parameterised counter with wrap and region-compare outputs, instantiated for the H and V axes.

Test Plan:
- Small params (H 8/2/3/3 giving H_TOTAL=16; V 4/1/2/1 giving V_TOTAL=8; HS_POL=VS_POL=1); enable held high from reset release -> de high 8 cycles, low 8, for 4 lines (32 de cycles per 128-cycle frame); first de and frame_start one edge after enable is sampled.
- Same params -> pixel_hs high at output h=10..12 each line; pixel_vs high for lines 5..6 (32 cycles); pixel_x 0..7 and pixel_y 0..3 during de, 0 elsewhere.
- enable dropped at line 1 of frame 0 -> frame completes (all 32 de cycles), frame_cnt=1, busy falls, de stays 0 afterwards.
- enable held high for 3 frames -> frame_start exactly every 128 cycles, frame_cnt=3, no gap cycles between frames.
- pixel_rst asserted mid-line at h=5, v=2 -> next edge de=0, hs/vs inactive, x=y=0, busy=0; re-enable restarts at (0,0).
- HS_POL=0, VS_POL=0 -> sync outputs inverted, reset levels 1; de timing unchanged.
